// File: rtl/noc_ram_arbiter_pkg.sv
// Shared constants and FSM encoding for the NoC RAM arbiter.
package noc_ram_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Width of an index able to hold values 0..n-1; never zero.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_ram_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester at or after
// last_grant+1 (wrapping) wins; output is one-hot, zero when nobody requests.
module rr_picker
  import noc_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  int pos;
  int best;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path
    // leaves one unassigned and a latch can never be inferred.
    grant = '0;
    best  = NUM_REQ;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Distance of requester k from the search start, 0 = highest priority.
      pos = (k + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
      if (req[k] && (pos < best)) begin
        best     = pos;
        grant    = '0;
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_ram_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one-at-a-time access to a
// single RAM command port, with per-transaction ack timeout.
module noc_ram_arbiter
  import noc_ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [NUM_REQ-1:0]            o_done,
  output logic [NUM_REQ-1:0]            o_err,
  output logic [DATA_WIDTH-1:0]         o_wdata,
  output logic [ADDR_WIDTH-1:0]         o_address,
  output logic                          o_read_write_enable,
  output logic                          o_en,
  input  logic                          i_write_ack,
  input  logic                          i_read_ack
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(TIMEOUT + 1);

  state_t                 state;
  logic [IDX_W-1:0]       last_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]     pick;
  logic [CNT_W-1:0]       wait_cnt;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_rw;
  logic                   ack_match;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (i_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // Encode the winner and mux out its command fields.
  always_comb begin
    pick_idx  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        pick_idx  = IDX_W'(k);
        sel_addr  = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        sel_rw    = i_rw[k];
      end
    end
  end

  // The latched op lives in o_read_write_enable; both acks together still match.
  assign ack_match = o_read_write_enable ? i_write_ack : i_read_ack;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state               <= S_IDLE;
      last_grant          <= IDX_W'(NUM_REQ - 1);
      wait_cnt            <= '0;
      o_grant             <= '0;
      o_done              <= '0;
      o_err               <= '0;
      o_wdata             <= '0;
      o_address           <= '0;
      o_read_write_enable <= 1'b0;
      o_en                <= 1'b0;
    end else begin
      o_done <= '0;
      o_err  <= '0;
      o_en   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|i_req) begin
            state               <= S_ISSUE;
            last_grant          <= pick_idx;
            o_grant             <= pick;
            o_en                <= 1'b1;
            o_address           <= sel_addr;
            o_wdata             <= sel_wdata;
            o_read_write_enable <= sel_rw;
          end
        end
        S_ISSUE: begin
          if (ack_match) begin
            state   <= S_IDLE;
            o_grant <= '0;
            o_done  <= o_grant;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (ack_match) begin
            state   <= S_IDLE;
            o_grant <= '0;
            o_done  <= o_grant;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // TIMEOUT silent WAIT cycles have elapsed.
            state   <= S_IDLE;
            o_grant <= '0;
            o_err   <= o_grant;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          o_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_ram_arbiter.sv
// Self-checking bench for noc_ram_arbiter: directed scenarios plus random
// transactions checked against a round-robin/timing reference model.
module tb_noc_ram_arbiter;

  localparam int NR = 4;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req, rw, grant, done, err;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wdata;
  logic [DW-1:0]     ram_wdata;
  logic [AW-1:0]     ram_addr;
  logic              ram_rw, ram_en, write_ack, read_ack;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int            exp_last = NR - 1;
  int            w;
  logic          exp_rw;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  noc_ram_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst_n),
    .i_req               (req),
    .i_rw                (rw),
    .i_addr              (addr),
    .i_wdata             (wdata),
    .o_grant             (grant),
    .o_done              (done),
    .o_err               (err),
    .o_wdata             (ram_wdata),
    .o_address           (ram_addr),
    .o_read_write_enable (ram_rw),
    .o_en                (ram_en),
    .i_write_ack         (write_ack),
    .i_read_ack          (read_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester after the last winner, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    logic [NR-1:0] t;
    for (int i = 1; i <= NR; i++) begin
      t = r >> ((last + i) % NR);
      if (t[0]) return (last + i) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int k);
    return NR'(1) << k;
  endfunction

  task automatic rand_inputs();
    logic [63:0] t;
    t     = {$urandom, $urandom};
    addr  = t[NR*AW-1:0];
    wdata = {$urandom, $urandom, $urandom, $urandom};
    rw    = NR'($urandom);
  endtask

  // Present a request set in an IDLE cycle and check the ISSUE cycle that follows.
  task automatic issue(input logic [NR-1:0] r, input string tag);
    logic [NR*AW-1:0] ta;
    logic [NR*DW-1:0] td;
    logic [NR-1:0]    tr;
    req       = r;
    w         = rr_pick(r, exp_last);
    tr        = rw >> w;
    ta        = addr >> (w * AW);
    td        = wdata >> (w * DW);
    exp_rw    = tr[0];
    exp_addr  = ta[AW-1:0];
    exp_wdata = td[DW-1:0];
    tick();
    check({tag, ":en"},    64'(ram_en),    64'(1));
    check({tag, ":grant"}, 64'(grant),     64'(onehot(w)));
    check({tag, ":addr"},  64'(ram_addr),  64'(exp_addr));
    check({tag, ":wdata"}, 64'(ram_wdata), 64'(exp_wdata));
    check({tag, ":rw"},    64'(ram_rw),    64'(exp_rw));
    check({tag, ":done0"}, 64'(done),      64'(0));
    check({tag, ":err0"},  64'(err),       64'(0));
    exp_last = w;
    // Winner's inputs change right after the grant; the transaction must not notice.
    rand_inputs();
    req = NR'($urandom);
  endtask

  // Let `delay` cycles pass after ISSUE (optionally with the wrong ack), then
  // ack; delay < 0 means never ack, so the timeout must fire.
  task automatic finish(input int delay, input bit noise, input string tag);
    int n;
    n = (delay < 0) ? TO : delay;
    for (int c = 0; c < n; c++) begin
      write_ack = exp_rw ? 1'b0 : noise;
      read_ack  = exp_rw ? noise : 1'b0;
      tick();
      check({tag, ":wait_en"},    64'(ram_en),   64'(0));
      check({tag, ":wait_grant"}, 64'(grant),    64'(onehot(w)));
      check({tag, ":wait_done"},  64'(done),     64'(0));
      check({tag, ":wait_err"},   64'(err),      64'(0));
      check({tag, ":wait_addr"},  64'(ram_addr), 64'(exp_addr));
      check({tag, ":wait_rw"},    64'(ram_rw),   64'(exp_rw));
    end
    if (delay < 0) begin
      write_ack = 1'b0;
      read_ack  = 1'b0;
    end else begin
      write_ack = exp_rw ? 1'b1 : noise;
      read_ack  = exp_rw ? noise : 1'b1;
    end
    tick();
    write_ack = 1'b0;
    read_ack  = 1'b0;
    check({tag, ":done"},  64'(done),  64'((delay < 0) ? '0 : onehot(w)));
    check({tag, ":err"},   64'(err),   64'((delay < 0) ? onehot(w) : '0));
    check({tag, ":idle_grant"}, 64'(grant), 64'(0));
    check({tag, ":idle_en"},    64'(ram_en), 64'(0));
    check({tag, ":hold_addr"},  64'(ram_addr),  64'(exp_addr));
    check({tag, ":hold_wdata"}, 64'(ram_wdata), 64'(exp_wdata));
  endtask

  initial begin
    int          d;
    bit          nz;
    logic [NR-1:0] r;

    rst_n = 1'b0; req = '0; rw = '0; addr = '0; wdata = '0;
    write_ack = 1'b0; read_ack = 1'b0;
    tick();
    tick();
    check("rst:grant", 64'(grant), 64'(0));
    check("rst:done",  64'(done),  64'(0));
    check("rst:err",   64'(err),   64'(0));
    check("rst:en",    64'(ram_en), 64'(0));
    check("rst:addr",  64'(ram_addr), 64'(0));
    check("rst:wdata", 64'(ram_wdata), 64'(0));
    check("rst:rw",    64'(ram_rw), 64'(0));
    rst_n = 1'b1;
    tick();
    check("idle:grant", 64'(grant), 64'(0));
    check("idle:en",    64'(ram_en), 64'(0));

    // Single write, ack two cycles after the command strobe.
    rw = 4'b0001;
    addr[AW-1:0]  = 14'h0010;
    wdata[DW-1:0] = 32'hDEADBEEF;
    issue(4'b0001, "wr");
    finish(2, 1'b0, "wr");

    // Read that is never acked, then a normal one from the same requester.
    rw = 4'b0000;
    issue(4'b0010, "to");
    finish(-1, 1'b0, "to");
    rw = 4'b0000;
    issue(4'b0010, "after_to");
    finish(1, 1'b0, "after_to");

    // Read that only sees write acks before its own ack.
    rw = 4'b0000;
    issue(4'b0100, "wrong_ack");
    finish(4, 1'b1, "wrong_ack");

    // Ack on the very last WAIT cycle still completes.
    rw = 4'b1111;
    issue(4'b1000, "last_wait");
    finish(TO, 1'b0, "last_wait");

    // Everyone holding requests with immediate acks: fair rotation.
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      issue(4'b1111, "rr");
      finish(0, 1'b0, "rr");
    end

    // Reset during WAIT abandons the transaction; later acks are ignored.
    rand_inputs();
    issue(4'b0100, "mid_rst");
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst:grant", 64'(grant), 64'(0));
    check("mid_rst:done",  64'(done),  64'(0));
    check("mid_rst:err",   64'(err),   64'(0));
    check("mid_rst:en",    64'(ram_en), 64'(0));
    check("mid_rst:addr",  64'(ram_addr), 64'(0));
    rst_n = 1'b1;
    req = '0;
    write_ack = 1'b1;
    read_ack  = 1'b1;
    tick();
    write_ack = 1'b0;
    read_ack  = 1'b0;
    check("late_ack:done",  64'(done),  64'(0));
    check("late_ack:err",   64'(err),   64'(0));
    check("late_ack:grant", 64'(grant), 64'(0));
    exp_last = NR - 1;
    rand_inputs();
    issue(4'b1111, "post_rst");
    finish(0, 1'b0, "post_rst");

    // Random traffic.
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      r  = NR'($urandom_range(1, (1 << NR) - 1));
      nz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) d = -1;
      else d = int'($urandom_range(0, TO));
      issue(r, "rnd");
      finish(d, nz, "rnd");
    end

    req = '0;
    tick();
    check("end:grant", 64'(grant), 64'(0));
    check("end:en",    64'(ram_en), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_ram_arbiter.md
NOC_RAM_ARBITER -- requirements
Module: noc_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one RAM port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, RAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, RAM data width.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for a RAM ack.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 i_clk  input  1  rising-edge clock.
REQ-007 i_rst  input  1  synchronous active-low reset.
REQ-008 i_req  input  NUM_REQ  per-requester request level.
REQ-009 i_rw  input  NUM_REQ  per-requester op, 1 = write, 0 = read.
REQ-010 i_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 i_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing.
REQ-012 o_grant  output  NUM_REQ  one-hot owner of the RAM port; zero when idle.
REQ-013 o_done  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-014 o_err  output  NUM_REQ  one-cycle timeout pulse to the owner.
REQ-015 o_wdata, o_address, o_read_write_enable, o_en  output  DATA_WIDTH, ADDR_WIDTH, 1, 1  RAM command port; o_read_write_enable 1 = write.
REQ-016 i_write_ack, i_read_ack  input  1 each  RAM completion strobes.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE.
REQ-018 IDLE: if any i_req set, SHALL select a winner by round-robin and go to ISSUE next cycle; otherwise stay.
REQ-019 Round-robin: search starts at requester (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-020 On grant SHALL latch winner's rw, addr and wdata; later changes on the winner's inputs SHALL NOT affect the transaction.
REQ-021 ISSUE: o_en = 1 for exactly one cycle with latched fields on o_address, o_wdata, o_read_write_enable; o_grant = winner.
REQ-022 o_grant SHALL stay asserted in ISSUE and WAIT and clear on the return to IDLE.
REQ-023 Matching ack (i_write_ack for write, i_read_ack for read) seen in ISSUE or WAIT SHALL produce o_done[winner] = 1 next cycle, with state IDLE that same cycle.
REQ-024 Non-matching ack SHALL be ignored; simultaneous write and read acks SHALL count as matching.
REQ-025 WAIT counter SHALL clear on entry and increment each WAIT cycle without a matching ack; at TIMEOUT it SHALL pulse o_err[winner] next cycle, with no o_done, and return to IDLE.
REQ-026 Deasserting i_req mid-transaction SHALL NOT abort it; completion or timeout still pulses to that requester.
REQ-027 Minimum request-to-request spacing: one IDLE cycle between transactions; back-to-back holders SHALL rotate fairly.
REQ-028 o_wdata, o_address and o_read_write_enable SHALL hold their last values outside ISSUE; o_en = 0 outside ISSUE.

Reset
REQ-029 On i_rst = 0 at a clock edge: state IDLE, all outputs 0, counter 0, last_grant = NUM_REQ-1.
REQ-030 Reset mid-transaction SHALL abandon it silently, with no o_done or o_err, and later acks SHALL be ignored while in IDLE.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the default width and TIMEOUT constants.
REQ-032 Round-robin selection SHALL be a sub-module rr_picker (inputs req, last_grant; output one-hot grant), purely combinational.
REQ-033 Top-level integration SHALL place noc_ram_arbiter between NUM_REQ decoders and the single RAM instance.

Verification
REQ-034 Single write: i_req = 0001, i_rw[0] = 1, addr 0x0010, data 0xDEADBEEF, ack 2 cycles after o_en -> o_en one cycle with those values; o_done = 0001 one cycle after ack.
REQ-035 All four requesting continuously, immediate acks -> grant order 0,1,2,3,0, each o_done once per round.
REQ-036 Read with no ack -> o_err[winner] pulses exactly TIMEOUT+1 cycles after the ISSUE cycle; no o_done; next request is served normally.
REQ-037 Read in flight, only i_write_ack pulses, then i_read_ack -> completion only after i_read_ack.
REQ-038 i_rst low during WAIT, then an ack arrives -> all outputs 0, no o_done, and requester 0 wins the next grant.
REQ-039 Winner changes i_addr and drops i_req the cycle after grant -> RAM sees the original address; o_done is still delivered.
